// File: rtl/video_timing_pkg.sv
// Default 15 kHz raster timing constants and counter widths shared by the
// video sync generator and its counters.
package video_timing_pkg;

  localparam int unsigned HCNT_W        = 10;
  localparam int unsigned VCNT_W        = 9;

  localparam int unsigned H_TOTAL       = 896;
  localparam int unsigned H_ACTIVE      = 512;
  localparam int unsigned H_BLANK_START = 576;
  localparam int unsigned H_BLANK_END   = 768;
  localparam int unsigned H_SYNC_START  = 640;
  localparam int unsigned H_SYNC_LEN    = 64;

  localparam int unsigned V_TOTAL_50    = 312;
  localparam int unsigned V_TOTAL_60    = 262;
  localparam int unsigned V_ACTIVE      = 240;
  localparam int unsigned V_BLANK_START = 244;
  localparam int unsigned V_SYNC_START  = 248;
  localparam int unsigned V_SYNC_LEN    = 4;

  localparam int unsigned INT_LEN       = 128;

  // Half-open window test [lo, hi) on zero-extended counter values.
  function automatic logic in_range(input int unsigned v,
                                    input int unsigned lo,
                                    input int unsigned hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Enable-gated up-counter that wraps to zero after reaching a runtime limit.
// Exposes both the current and the next-state value so that decodes can be
// registered on the same edge as the count.
module wrap_counter #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_next,
  output logic         wrap
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // A count at or beyond the limit wraps, so a shortened limit can never
  // leave the counter running away.
  assign wrap = en && (cnt_q >= limit);

  // Next count: hold without enable, otherwise increment or wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign cnt_next = cnt_d;

endmodule

// File: rtl/video_sync_gen.sv
// 15 kHz raster timing generator: h/v counters, active-low syncs, blanking,
// display enable, line/frame strobes and the Z80 frame interrupt. All state
// advances on the 14 MHz tick (clk28en & clk14en).
module video_sync_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL       = video_timing_pkg::H_TOTAL,
  parameter int unsigned H_ACTIVE      = video_timing_pkg::H_ACTIVE,
  parameter int unsigned H_BLANK_START = video_timing_pkg::H_BLANK_START,
  parameter int unsigned H_BLANK_END   = video_timing_pkg::H_BLANK_END,
  parameter int unsigned H_SYNC_START  = video_timing_pkg::H_SYNC_START,
  parameter int unsigned H_SYNC_LEN    = video_timing_pkg::H_SYNC_LEN,
  parameter int unsigned V_TOTAL_50    = video_timing_pkg::V_TOTAL_50,
  parameter int unsigned V_TOTAL_60    = video_timing_pkg::V_TOTAL_60,
  parameter int unsigned V_ACTIVE      = video_timing_pkg::V_ACTIVE,
  parameter int unsigned V_BLANK_START = video_timing_pkg::V_BLANK_START,
  parameter int unsigned V_SYNC_START  = video_timing_pkg::V_SYNC_START,
  parameter int unsigned V_SYNC_LEN    = video_timing_pkg::V_SYNC_LEN,
  parameter int unsigned INT_LEN       = video_timing_pkg::INT_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk28en,
  input  logic              clk14en,
  input  logic              mode_60hz,
  output logic [HCNT_W-1:0] hcnt,
  output logic [VCNT_W-1:0] vcnt,
  output logic              hsync_n,
  output logic              vsync_n,
  output logic              csync_n,
  output logic              blank,
  output logic              de,
  output logic              line_start,
  output logic              frame_start,
  output logic              int_n
);

  localparam int unsigned INT_W = $clog2(INT_LEN + 1);

  logic              tick;
  logic [HCNT_W-1:0] hcnt_cur, hcnt_nxt;
  logic [VCNT_W-1:0] vcnt_cur, vcnt_nxt;
  logic              hwrap, vwrap;
  logic [VCNT_W-1:0] vlimit;
  logic              mode_sel;

  logic              mode_q, mode_d;
  logic              init_q, init_d;
  logic [INT_W-1:0]  int_cnt_q, int_cnt_d;
  logic              hsync_n_q, hsync_n_d;
  logic              vsync_n_q, vsync_n_d;
  logic              csync_n_q, csync_n_d;
  logic              blank_q, blank_d;
  logic              de_q, de_d;
  logic              line_start_q, line_start_d;
  logic              frame_start_q, frame_start_d;
  logic              int_n_q, int_n_d;
  logic              int_trig;

  assign tick = clk28en & clk14en;

  // Until the first tick after reset the frame length follows mode_60hz
  // directly; afterwards only the latched copy (updated at frame wrap) counts.
  assign mode_sel = init_q ? mode_60hz : mode_q;
  assign vlimit   = mode_sel ? VCNT_W'(V_TOTAL_60 - 1) : VCNT_W'(V_TOTAL_50 - 1);

  wrap_counter #(.W(HCNT_W)) u_hcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tick),
    .limit    (HCNT_W'(H_TOTAL - 1)),
    .cnt      (hcnt_cur),
    .cnt_next (hcnt_nxt),
    .wrap     (hwrap)
  );

  // vcnt steps once per line; its wrap is therefore also the frame wrap.
  wrap_counter #(.W(VCNT_W)) u_vcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tick & hwrap),
    .limit    (vlimit),
    .cnt      (vcnt_cur),
    .cnt_next (vcnt_nxt),
    .wrap     (vwrap)
  );

  // Decode the next-state counters so registered outputs line up with hcnt/vcnt.
  always_comb begin
    mode_d        = mode_q;
    init_d        = init_q;
    int_cnt_d     = int_cnt_q;
    hsync_n_d     = hsync_n_q;
    vsync_n_d     = vsync_n_q;
    csync_n_d     = csync_n_q;
    blank_d       = blank_q;
    de_d          = de_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    int_n_d       = int_n_q;
    int_trig      = 1'b0;
    if (tick) begin
      init_d = 1'b0;
      if (init_q || vwrap) begin
        mode_d = mode_60hz;
      end
      hsync_n_d = !in_range(32'(hcnt_nxt), H_SYNC_START, H_SYNC_START + H_SYNC_LEN);
      vsync_n_d = !in_range(32'(vcnt_nxt), V_SYNC_START, V_SYNC_START + V_SYNC_LEN);
      // XNOR of the two active-low syncs inverts hsync during vsync (serration).
      csync_n_d = ~(hsync_n_d ^ vsync_n_d);
      blank_d   = in_range(32'(hcnt_nxt), H_BLANK_START, H_BLANK_END) ||
                  (32'(vcnt_nxt) >= V_BLANK_START);
      de_d      = (32'(hcnt_nxt) < H_ACTIVE) && (32'(vcnt_nxt) < V_ACTIVE);
      line_start_d  = hwrap;
      frame_start_d = vwrap;
      int_trig  = (32'(vcnt_nxt) == V_SYNC_START) && (hcnt_nxt == '0);
      if (int_trig) begin
        int_cnt_d = INT_W'(INT_LEN);
      end else if (int_cnt_q != '0) begin
        int_cnt_d = int_cnt_q - INT_W'(1);
      end
      int_n_d = (int_cnt_d == '0);
    end
  end

  // Output and control registers; reset values match the (0,0) decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q        <= 1'b0;
      init_q        <= 1'b1;
      int_cnt_q     <= '0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      csync_n_q     <= 1'b1;
      blank_q       <= 1'b0;
      de_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      int_n_q       <= 1'b1;
    end else begin
      mode_q        <= mode_d;
      init_q        <= init_d;
      int_cnt_q     <= int_cnt_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      csync_n_q     <= csync_n_d;
      blank_q       <= blank_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      int_n_q       <= int_n_d;
    end
  end

  assign hcnt        = hcnt_cur;
  assign vcnt        = vcnt_cur;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign csync_n     = csync_n_q;
  assign blank       = blank_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign int_n       = int_n_q;

endmodule

// File: tb/tb_video_sync_gen.sv
// Directed bench for video_sync_gen using a scaled raster (64 ticks/line,
// 20/16 lines/frame) so whole frames fit in a short run.
module tb_video_sync_gen;

  localparam int unsigned HT  = 64;
  localparam int unsigned HA  = 32;
  localparam int unsigned HBS = 36;
  localparam int unsigned HBE = 52;
  localparam int unsigned HSS = 40;
  localparam int unsigned HSL = 8;
  localparam int unsigned V50 = 20;
  localparam int unsigned V60 = 16;
  localparam int unsigned VA  = 10;
  localparam int unsigned VBS = 11;
  localparam int unsigned VSS = 12;
  localparam int unsigned VSL = 2;
  localparam int unsigned IL  = 48;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk28en;
  logic       clk14en;
  logic       mode_60hz;
  logic [9:0] hcnt;
  logic [8:0] vcnt;
  logic       hsync_n, vsync_n, csync_n, blank, de;
  logic       line_start, frame_start, int_n;

  int errors = 0;
  int checks = 0;

  video_sync_gen #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .H_BLANK_START(HBS), .H_BLANK_END(HBE),
    .H_SYNC_START(HSS), .H_SYNC_LEN(HSL), .V_TOTAL_50(V50), .V_TOTAL_60(V60),
    .V_ACTIVE(VA), .V_BLANK_START(VBS), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL),
    .INT_LEN(IL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk28en(clk28en), .clk14en(clk14en),
    .mode_60hz(mode_60hz), .hcnt(hcnt), .vcnt(vcnt), .hsync_n(hsync_n),
    .vsync_n(vsync_n), .csync_n(csync_n), .blank(blank), .de(de),
    .line_start(line_start), .frame_start(frame_start), .int_n(int_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n clocks, leaving the bench 1 time unit after the last edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hcnt"}, 32'(hcnt), 0);
    chk({tag, "_vcnt"}, 32'(vcnt), 0);
    chk({tag, "_hsync_n"}, 32'(hsync_n), 1);
    chk({tag, "_vsync_n"}, 32'(vsync_n), 1);
    chk({tag, "_csync_n"}, 32'(csync_n), 1);
    chk({tag, "_blank"}, 32'(blank), 0);
    chk({tag, "_de"}, 32'(de), 1);
    chk({tag, "_line_start"}, 32'(line_start), 0);
    chk({tag, "_frame_start"}, 32'(frame_start), 0);
    chk({tag, "_int_n"}, 32'(int_n), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    clk28en   = 1'b1;
    clk14en   = 1'b1;
    mode_60hz = 1'b0;
    run(3);
    chk_reset_vals("rst");

    rst_n = 1'b1;
    run(1);
    chk("first_tick_hcnt", 32'(hcnt), 1);
    chk("first_tick_line_start", 32'(line_start), 0);
    chk("first_tick_frame_start", 32'(frame_start), 0);
    run(62);
    chk("pre_wrap_hcnt", 32'(hcnt), 63);
    chk("pre_wrap_vcnt", 32'(vcnt), 0);
    run(1);
    chk("hwrap_hcnt", 32'(hcnt), 0);
    chk("hwrap_vcnt", 32'(vcnt), 1);
    chk("hwrap_line_start", 32'(line_start), 1);
    chk("hwrap_frame_start", 32'(frame_start), 0);
    chk("l1_h0_hsync_n", 32'(hsync_n), 1);
    chk("l1_h0_blank", 32'(blank), 0);
    chk("l1_h0_de", 32'(de), 1);

    // Line 1: hsync 40..47, blank 36..51, de 0..31.
    for (int h = 1; h < 64; h++) begin
      run(1);
      chk("l1_hcnt", 32'(hcnt), 32'(h));
      chk("l1_hsync_n", 32'(hsync_n), (h >= 40 && h < 48) ? 0 : 1);
      chk("l1_blank", 32'(blank), (h >= 36 && h < 52) ? 1 : 0);
      chk("l1_de", 32'(de), (h < 32) ? 1 : 0);
      if (h == 1) chk("l1_line_start_drop", 32'(line_start), 0);
    end

    // Into the vsync line.
    run(640);
    chk("l11_vcnt", 32'(vcnt), 11);
    chk("l11_vsync_n", 32'(vsync_n), 1);
    chk("l11_int_n", 32'(int_n), 1);
    chk("l11_blank", 32'(blank), 1);
    run(1);
    chk("l12_vcnt", 32'(vcnt), 12);
    chk("l12_hcnt", 32'(hcnt), 0);
    chk("l12_vsync_n", 32'(vsync_n), 0);
    chk("l12_csync_n", 32'(csync_n), 0);
    chk("l12_int_n", 32'(int_n), 0);
    chk("l12_de", 32'(de), 0);
    for (int h = 1; h < 64; h++) begin
      run(1);
      chk("l12_vsync_n_loop", 32'(vsync_n), 0);
      chk("l12_csync_n_loop", 32'(csync_n), (h >= 40 && h < 48) ? 1 : 0);
      chk("l12_int_n_loop", 32'(int_n), (h < 48) ? 0 : 1);
    end

    // Enable gating mid-line.
    run(5);
    chk("gate_pre_hcnt", 32'(hcnt), 4);
    chk("gate_pre_vcnt", 32'(vcnt), 13);
    clk14en = 1'b0;
    run(50);
    chk("gate14_hcnt", 32'(hcnt), 4);
    chk("gate14_vcnt", 32'(vcnt), 13);
    chk("gate14_vsync_n", 32'(vsync_n), 0);
    chk("gate14_hsync_n", 32'(hsync_n), 1);
    chk("gate14_blank", 32'(blank), 1);
    chk("gate14_int_n", 32'(int_n), 1);
    clk14en = 1'b1;
    clk28en = 1'b0;
    run(7);
    chk("gate28_hcnt", 32'(hcnt), 4);
    clk28en = 1'b1;
    run(1);
    chk("resume_hcnt", 32'(hcnt), 5);

    // 50 Hz frame wraps at 19 -> 0.
    run(442);
    chk("f50_last_vcnt", 32'(vcnt), 19);
    chk("f50_last_hcnt", 32'(hcnt), 63);
    chk("f50_last_frame_start", 32'(frame_start), 0);
    run(1);
    chk("f50_wrap_vcnt", 32'(vcnt), 0);
    chk("f50_wrap_frame_start", 32'(frame_start), 1);
    chk("f50_wrap_line_start", 32'(line_start), 1);
    run(1);
    chk("f50_frame_start_drop", 32'(frame_start), 0);

    // Switch to 60 Hz mid-frame: this frame still ends at 19, next at 15.
    run(319);
    chk("mode_sw_vcnt", 32'(vcnt), 5);
    mode_60hz = 1'b1;
    run(959);
    chk("sw_frame_last_vcnt", 32'(vcnt), 19);
    run(1);
    chk("sw_frame_wrap_vcnt", 32'(vcnt), 0);
    chk("sw_frame_wrap_frame_start", 32'(frame_start), 1);
    run(1023);
    chk("f60_last_vcnt", 32'(vcnt), 15);
    chk("f60_last_hcnt", 32'(hcnt), 63);
    chk("f60_last_frame_start", 32'(frame_start), 0);
    run(1);
    chk("f60_wrap_vcnt", 32'(vcnt), 0);
    chk("f60_wrap_frame_start", 32'(frame_start), 1);

    // Asynchronous reset inside hsync, vsync and the interrupt pulse.
    run(810);
    chk("prerst_vcnt", 32'(vcnt), 12);
    chk("prerst_hcnt", 32'(hcnt), 42);
    chk("prerst_hsync_n", 32'(hsync_n), 0);
    chk("prerst_vsync_n", 32'(vsync_n), 0);
    chk("prerst_csync_n", 32'(csync_n), 1);
    chk("prerst_int_n", 32'(int_n), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    run(2);
    chk("rst_hold_hcnt", 32'(hcnt), 0);
    rst_n = 1'b1;
    run(60);
    chk("post_rst_hcnt", 32'(hcnt), 60);
    chk("post_rst_int_n", 32'(int_n), 1);
    chk("post_rst_line_start", 32'(line_start), 0);
    // Reset picked up mode_60hz=1 directly: 16-line frame.
    run(963);
    chk("post_rst_last_vcnt", 32'(vcnt), 15);
    run(1);
    chk("post_rst_wrap_vcnt", 32'(vcnt), 0);
    chk("post_rst_wrap_frame_start", 32'(frame_start), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
